sal_rd_resp: RTL and testbench

Read-response path of the SAL DDR2 controller: returns DFI read data to the AXI R channel, the responder end of the AXI AR requests taken by the address decoder. The scheduler pushes one tag (AXI ID) per issued read command; DFI read beats, which cannot be back-pressured, are buffered and paired in order with tags to form AXI R bursts with RID and RLAST. Sits between the DFI read interface and the AXI R interface, beside the scheduler.

---
 rtl/sal_rd_resp.sv | 188 ++++++++++++++++++
 tb/tb_sal_rd_resp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_rd_resp.sv
// ============================================================================
// sal_rd_resp -- read-response path of the SAL DDR2 controller.
//
// Pairs DFI read beats (which cannot be back-pressured) with the AXI IDs that
// the scheduler pushes for every issued read command, and presents the result
// as AXI R bursts of BURST_LEN beats with RID/RLAST. Tags are served strictly
// in issue order.
//
// Ports:
//   clk, rst            controller clock, asynchronous active-high reset
//   rd_tag_valid/_id    scheduler pushes one AXI ID per read command
//   rd_tag_ready        tag FIFO not full (low while in reset)
//   dfi_rddata_valid    DFI read beat strobe
//   dfi_rddata          DFI read beat
//   dfi_rddata_par      per-byte even parity (only with SAL_RD_RESP_PARITY_EN)
//   rvalid/rready       AXI R handshake
//   rid/rdata/rresp/rlast  AXI R payload
//   err_orphan          sticky: beat arrived with no outstanding command
//   err_overflow        sticky: beat arrived with the data FIFO full
//
// Handshake: a beat transfers on a cycle where rvalid && rready at the rising
// clock edge; once rvalid is high the payload holds until that transfer.
//
// Configuration macro: SAL_RD_RESP_PARITY_EN -- when defined, a parity bit per
// data byte is stored with each beat and checked on output; a mismatch turns
// that beat's rresp into SLVERR (2'b10). When undefined, rresp is always OKAY.
// ============================================================================
module sal_rd_resp #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_tag_valid,
    input  logic [ID_WIDTH-1:0]   rd_tag_id,
    output logic                  rd_tag_ready,
    input  logic                  dfi_rddata_valid,
    input  logic [DATA_WIDTH-1:0] dfi_rddata,
`ifdef SAL_RD_RESP_PARITY_EN
    input  logic [DATA_WIDTH/8-1:0] dfi_rddata_par,
`endif
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  err_orphan,
    output logic                  err_overflow
);

    localparam int DATA_DEPTH = TAG_DEPTH * BURST_LEN;
    localparam int TAG_AW     = $clog2(TAG_DEPTH);
    localparam int DATA_AW    = $clog2(DATA_DEPTH);
    localparam int BEAT_W     = $clog2(BURST_LEN);
    localparam int OUT_W      = DATA_AW + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [OUT_W-1:0]  BL_INC    = OUT_W'(BURST_LEN);
    localparam logic [OUT_W-1:0]  ONE_DEC   = OUT_W'(1);

    // ------------------------------------------------------------------
    // Storage and pointers (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]   r_tag_mem [TAG_DEPTH];
    logic [TAG_AW:0]       r_tag_wr;
    logic [TAG_AW:0]       r_tag_rd;

    logic [DATA_WIDTH-1:0] r_dat_mem [DATA_DEPTH];
    logic [DATA_AW:0]      r_dat_wr;
    logic [DATA_AW:0]      r_dat_rd;
`ifdef SAL_RD_RESP_PARITY_EN
    logic [DATA_WIDTH/8-1:0] r_par_mem [DATA_DEPTH];
`endif

    logic [OUT_W-1:0]      r_out_cnt;   // DFI beats still owed to pushed tags
    logic [BEAT_W-1:0]     r_beat_cnt;  // position inside the current R burst
    logic                  r_live;      // low only until the first edge after reset
    logic                  r_err_orphan;
    logic                  r_err_overflow;

    logic w_tag_empty, w_tag_full, w_dat_empty, w_dat_full;
    logic w_tag_push, w_tag_pop, w_dat_push, w_dat_pop;
    logic w_rvalid, w_last_beat, w_orphan, w_overflow, w_beat_owed;
    logic [OUT_W-1:0] w_out_nxt;

    assign w_tag_empty = (r_tag_wr == r_tag_rd);
    assign w_tag_full  = (r_tag_wr[TAG_AW] != r_tag_rd[TAG_AW]) &&
                         (r_tag_wr[TAG_AW-1:0] == r_tag_rd[TAG_AW-1:0]);
    assign w_dat_empty = (r_dat_wr == r_dat_rd);
    assign w_dat_full  = (r_dat_wr[DATA_AW] != r_dat_rd[DATA_AW]) &&
                         (r_dat_wr[DATA_AW-1:0] == r_dat_rd[DATA_AW-1:0]);

    assign rd_tag_ready = r_live && !w_tag_full;
    assign w_tag_push   = rd_tag_valid && rd_tag_ready;

    assign w_rvalid    = !w_dat_empty && !w_tag_empty;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_dat_pop   = w_rvalid && rready;
    assign w_tag_pop   = w_dat_pop && w_last_beat;

    // A beat is only accepted if some pushed tag still expects data. When the
    // data FIFO is full, a same-cycle pop frees the slot being written.
    assign w_beat_owed = (r_out_cnt != '0);
    assign w_orphan    = dfi_rddata_valid && !w_beat_owed;
    assign w_overflow  = dfi_rddata_valid && w_beat_owed && w_dat_full && !w_dat_pop;
    assign w_dat_push  = dfi_rddata_valid && w_beat_owed && (!w_dat_full || w_dat_pop);

    always_comb begin
        w_out_nxt = r_out_cnt;
        if (w_tag_push) w_out_nxt = w_out_nxt + BL_INC;
        if (w_dat_push) w_out_nxt = w_out_nxt - ONE_DEC;
    end

    // ------------------------------------------------------------------
    // Memories (no reset needed; pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tag_push) r_tag_mem[r_tag_wr[TAG_AW-1:0]] <= rd_tag_id;
        if (w_dat_push) r_dat_mem[r_dat_wr[DATA_AW-1:0]] <= dfi_rddata;
`ifdef SAL_RD_RESP_PARITY_EN
        if (w_dat_push) r_par_mem[r_dat_wr[DATA_AW-1:0]] <= dfi_rddata_par;
`endif
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr       <= '0;
            r_tag_rd       <= '0;
            r_dat_wr       <= '0;
            r_dat_rd       <= '0;
            r_out_cnt      <= '0;
            r_beat_cnt     <= '0;
            r_live         <= 1'b0;
            r_err_orphan   <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_out_cnt <= w_out_nxt;
            if (w_tag_push) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_tag_pop)  r_tag_rd <= r_tag_rd + 1'b1;
            if (w_dat_push) r_dat_wr <= r_dat_wr + 1'b1;
            if (w_dat_pop) begin
                r_dat_rd   <= r_dat_rd + 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;  // BURST_LEN is a power of 2: wraps
            end
            if (w_orphan)   r_err_orphan   <= 1'b1;
            if (w_overflow) r_err_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // R channel outputs; payload forced to zero while nothing is valid
    // ------------------------------------------------------------------
    assign rvalid       = w_rvalid;
    assign rid          = w_rvalid ? r_tag_mem[r_tag_rd[TAG_AW-1:0]] : '0;
    assign rdata        = w_rvalid ? r_dat_mem[r_dat_rd[DATA_AW-1:0]] : '0;
    assign rlast        = w_rvalid && w_last_beat;
    assign err_orphan   = r_err_orphan;
    assign err_overflow = r_err_overflow;

`ifdef SAL_RD_RESP_PARITY_EN
    logic [DATA_WIDTH/8-1:0] w_head_par;
    logic                    w_par_err;

    assign w_head_par = r_par_mem[r_dat_rd[DATA_AW-1:0]];

    // Even parity: each data byte together with its parity bit has an even
    // number of ones.
    always_comb begin
        w_par_err = 1'b0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if ((^r_dat_mem[r_dat_rd[DATA_AW-1:0]][b*8 +: 8]) != w_head_par[b])
                w_par_err = 1'b1;
        end
    end

    assign rresp = (w_rvalid && w_par_err) ? 2'b10 : 2'b00;
`else
    assign rresp = 2'b00;
`endif

endmodule

// File: tb/tb_sal_rd_resp.sv
// ============================================================================
// tb_sal_rd_resp -- self-checking bench for sal_rd_resp.
//
// Reference model: tags are a list of IDs; every accepted DFI beat belongs to
// the oldest tag still owed data, so its expected R beat (ID, data, last flag,
// response) is known the moment the beat is applied and is queued in exp_q.
// The monitor pops exp_q on every R handshake. rvalid is expected exactly when
// exp_q is non-empty; rd_tag_ready when fewer than TAG_DEPTH tags are held.
// ============================================================================
module tb_sal_rd_resp;

    localparam int IDW = 4;
    localparam int DW  = 64;
    localparam int BL  = 4;
    localparam int TD  = 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
        logic [1:0]     resp;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           rd_tag_valid = 1'b0;
    logic [IDW-1:0] rd_tag_id = '0;
    logic           rd_tag_ready;
    logic           dfi_rddata_valid = 1'b0;
    logic [DW-1:0]  dfi_rddata = '0;
    logic           rvalid;
    logic           rready = 1'b0;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           err_orphan;
    logic           err_overflow;
`ifdef SAL_RD_RESP_PARITY_EN
    logic [DW/8-1:0] dfi_rddata_par = '0;
`endif

    sal_rd_resp #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .BURST_LEN(BL), .TAG_DEPTH(TD)) dut (
        .clk              (clk),
        .rst              (rst),
        .rd_tag_valid     (rd_tag_valid),
        .rd_tag_id        (rd_tag_id),
        .rd_tag_ready     (rd_tag_ready),
        .dfi_rddata_valid (dfi_rddata_valid),
        .dfi_rddata       (dfi_rddata),
`ifdef SAL_RD_RESP_PARITY_EN
        .dfi_rddata_par   (dfi_rddata_par),
`endif
        .rvalid           (rvalid),
        .rready           (rready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .err_orphan       (err_orphan),
        .err_overflow     (err_overflow)
    );

    // ---------------- reference model state ----------------
    beat_t          exp_q[$];
    logic [IDW-1:0] pend_q[$];     // tags still owed data, oldest first
    int             pend_beat = 0; // beats already received for pend_q[0]
    int             m_tag_cnt = 0; // tags held in the DUT
    int             m_out     = 0; // beats owed
    bit             m_live    = 0;
    bit             m_orphan  = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW/8-1:0] par_of(input logic [DW-1:0] d);
        logic [DW/8-1:0] p;
        for (int b = 0; b < DW / 8; b++) p[b] = ^d[b*8 +: 8];
        return p;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    // Inputs change only just after a rising edge, so at the falling edge they
    // are exactly what the DUT will act on at the next rising edge.
    always @(negedge clk) begin
        bit    exp_ready;
        beat_t e;
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            pend_beat = 0;
            m_tag_cnt = 0;
            m_out     = 0;
            m_live    = 0;
            m_orphan  = 0;
            chk("rst_tag_ready", rd_tag_ready, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rid", rid, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rresp", rresp, 0);
            chk("rst_rlast", rlast, 0);
            chk("rst_err_orphan", err_orphan, 0);
            chk("rst_err_overflow", err_overflow, 0);
        end else begin
            exp_ready = m_live && (m_tag_cnt < TD);
            chk("tag_ready", rd_tag_ready, exp_ready);
            chk("rvalid", rvalid, exp_q.size() != 0);
            chk("err_orphan", err_orphan, m_orphan);
            chk("err_overflow", err_overflow, 0);

            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rid", rid, e.id);
                    chk("rdata", rdata, e.data);
                    chk("rlast", rlast, e.last);
                    chk("rresp", rresp, e.resp);
                    if (e.last) m_tag_cnt--;
                end
            end

            // Beat acceptance uses the owed count before this edge's tag push.
            if (dfi_rddata_valid) begin
                if (m_out == 0) begin
                    m_orphan = 1;
                end else begin
                    e.id   = pend_q[0];
                    e.data = dfi_rddata;
                    e.last = (pend_beat == BL - 1);
                    e.resp = 2'b00;
`ifdef SAL_RD_RESP_PARITY_EN
                    if (dfi_rddata_par != par_of(dfi_rddata)) e.resp = 2'b10;
`endif
                    exp_q.push_back(e);
                    m_out--;
                    pend_beat++;
                    if (pend_beat == BL) begin
                        pend_beat = 0;
                        void'(pend_q.pop_front());
                    end
                end
            end

            if (rd_tag_valid && exp_ready) begin
                pend_q.push_back(rd_tag_id);
                m_tag_cnt++;
                m_out += BL;
            end
            m_live = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [IDW-1:0] id);
        rd_tag_valid = 1'b1;
        rd_tag_id    = id;
        tick();
        rd_tag_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input bit bad_par);
        dfi_rddata = d;
`ifdef SAL_RD_RESP_PARITY_EN
        dfi_rddata_par = par_of(d) ^ {{(DW/8-1){1'b0}}, bad_par};
`else
        if (bad_par) dfi_rddata[0] = dfi_rddata[0];
`endif
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit bad_par);
        dfi_rddata_valid = 1'b1;
        drive_beat(d, bad_par);
        tick();
        dfi_rddata_valid = 1'b0;
    endtask

    task automatic drain(input int limit, input bit toggle);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            rready = toggle ? ~rready : 1'b1;
            tick();
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        rready = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single burst, ID 3, data A0..A3, rready held high.
        rready = 1'b1;
        push_tag(4'h3);
        for (int i = 0; i < BL; i++) send_beat(64'hA0 + 64'(i), i == 1);
        drain(20, 0);

        // Eight tags back to back (ninth attempt must be refused), then
        // 32 beats with rready toggling.
        for (int i = 0; i < TD + 1; i++) push_tag(IDW'(i));
        for (int i = 0; i < TD * BL; i++) begin
            rready = i[0];
            send_beat(64'h1000 + 64'(i), 0);
        end
        drain(200, 1);

        // Orphan beat: no tag outstanding.
        send_beat(64'hDEAD, 0);
        repeat (3) tick();

        // Reset after two of four beats delivered, then a clean burst.
        rready = 1'b0;
        push_tag(4'h5);
        for (int i = 0; i < BL; i++) send_beat(64'hC0 + 64'(i), 0);
        rready = 1'b1;
        repeat (2) tick();
        rready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        push_tag(4'h9);
        rready = 1'b1;
        for (int i = 0; i < BL; i++) send_beat(64'hB0 + 64'(i), 0);
        drain(20, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rd_tag_valid     = ($urandom_range(0, 2) == 0);
            rd_tag_id        = IDW'($urandom);
            dfi_rddata_valid = (m_out > 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 49) == 0);
            drive_beat({$urandom, $urandom}, $urandom_range(0, 7) == 0);
            rready           = ($urandom_range(0, 3) != 0);
            tick();
        end
        rd_tag_valid     = 1'b0;
        dfi_rddata_valid = 1'b0;

        // Supply the beats still owed, then drain.
        rready = 1'b1;
        for (int k = 0; k < 200 && m_out > 0; k++) send_beat({$urandom, $urandom}, 0);
        drain(400, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
